// File: rtl/ccsds_pkg.sv
// Shared types and puncturing tables for the CCSDS convolutional encoder family.
// Keep masks are packed per position p as {keep_c1, keep_c2}, position 0 in the LSBs.
package ccsds_pkg;

   typedef enum logic [2:0] {
      RATE_1_2 = 3'd0,
      RATE_2_3 = 3'd1,
      RATE_3_4 = 3'd2,
      RATE_5_6 = 3'd3,
      RATE_7_8 = 3'd4
   } rate_e;

   localparam logic [6:0] CCSDS_G1 = 7'o171;
   localparam logic [6:0] CCSDS_G2 = 7'o133;

   localparam logic [13:0] KEEP_1_2 = {12'b0, 2'b11};
   localparam logic [13:0] KEEP_2_3 = {10'b0, 2'b01, 2'b11};
   localparam logic [13:0] KEEP_3_4 = {8'b0, 2'b10, 2'b01, 2'b11};
   localparam logic [13:0] KEEP_5_6 = {4'b0, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11};
   localparam logic [13:0] KEEP_7_8 = {2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b11};

   // Reserved rate codes fall back to rate 1/2.
   function automatic rate_e rate_decode(input logic [2:0] code);
      return (code > 3'd4) ? RATE_1_2 : rate_e'(code);
   endfunction

   function automatic logic [2:0] punct_period(input rate_e r);
      case (r)
         RATE_2_3: return 3'd2;
         RATE_3_4: return 3'd3;
         RATE_5_6: return 3'd5;
         RATE_7_8: return 3'd7;
         default:  return 3'd1;
      endcase
   endfunction

   function automatic logic [1:0] punct_keep(input rate_e r, input logic [2:0] p);
      logic [13:0] m;
      case (r)
         RATE_2_3: m = KEEP_2_3;
         RATE_3_4: m = KEEP_3_4;
         RATE_5_6: m = KEEP_5_6;
         RATE_7_8: m = KEEP_7_8;
         default:  m = KEEP_1_2;
      endcase
      return m[{p, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/ccsds_conv_core.sv
// Convolutional encoder core: K-1 bit history plus two parity taps, both
// combinational on {bit, history}; the history shifts only when enabled.
module ccsds_conv_core
   import ccsds_pkg::*;
#(
   parameter int             K       = 7,
   parameter logic [K-1:0]   G1_POLY = CCSDS_G1,
   parameter logic [K-1:0]   G2_POLY = CCSDS_G2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic bit_i,
   output logic c1_o,
   output logic c2_o
);

   logic [K-2:0] sr;
   logic [K-1:0] taps;

   assign taps = {bit_i, sr};
   assign c1_o = ^(G1_POLY & taps);
   assign c2_o = ^(G2_POLY & taps);

   // sr[K-2] is the most recent past bit, matching the MSB-is-current tap order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sr <= '0;
      end else if (en_i) begin
         sr <= {bit_i, sr[K-2:1]};
      end
   end

endmodule

// File: rtl/ccsds_punctured_conv_encoder.sv
// Punctured CCSDS convolutional encoder with per-frame tail termination and
// valid/ready handshakes; one input position fills a two-symbol output buffer.
module ccsds_punctured_conv_encoder
   import ccsds_pkg::*;
#(
   parameter int           K         = 7,
   parameter logic [K-1:0] G1_POLY   = CCSDS_G1,
   parameter logic [K-1:0] G2_POLY   = CCSDS_G2,
   parameter bit           INVERT_G2 = 1'b1,
   parameter bit           TAIL_EN   = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] rate_i,
   input  logic       data_i,
   input  logic       valid_i,
   input  logic       last_i,
   output logic       ready_o,
   output logic       data_o,
   output logic       valid_o,
   output logic       last_o,
   input  logic       ready_i,
   output logic       busy_o
);

   typedef enum logic [1:0] {IDLE, ENCODE, FLUSH, DRAIN} state_e;

   localparam int TW = $clog2(K);

   state_e        state_q, state_d;
   rate_e         rate_q, rate_eff;
   logic [2:0]    p_q;
   logic [TW-1:0] tail_q;
   logic [1:0]    sym_buf_p1;
   logic [1:0]    sym_cnt_p1;
   logic          last_p1;

   logic          take_in, inject, step, enc_bit, tail_done, final_bit, pop;
   logic          c1, c2, c2_sym;
   logic [1:0]    keep;

   ccsds_conv_core #(.K(K), .G1_POLY(G1_POLY), .G2_POLY(G2_POLY)) u_core (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (step),
      .bit_i  (enc_bit),
      .c1_o   (c1),
      .c2_o   (c2)
   );

   assign ready_o   = (sym_cnt_p1 == 2'd0) && (state_q == IDLE || state_q == ENCODE);
   assign take_in   = valid_i && ready_o;
   assign inject    = (state_q == FLUSH) && (sym_cnt_p1 == 2'd0);
   assign step      = take_in || inject;
   assign enc_bit   = inject ? 1'b0 : data_i;
   assign tail_done = (tail_q == TW'(K - 2));
   assign final_bit = inject ? tail_done : (take_in && last_i && !TAIL_EN);

   // The first bit of a frame is encoded with the rate presented on that cycle.
   assign rate_eff  = (state_q == IDLE) ? rate_decode(rate_i) : rate_q;
   assign keep      = punct_keep(rate_eff, p_q);
   assign c2_sym    = c2 ^ (INVERT_G2 && (rate_eff == RATE_1_2));

   assign valid_o   = (sym_cnt_p1 != 2'd0);
   assign data_o    = valid_o & sym_buf_p1[0];
   assign last_o    = last_p1 && (sym_cnt_p1 == 2'd1);
   assign pop       = valid_o && ready_i;
   assign busy_o    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ENCODE: if (take_in) state_d = last_i ? (TAIL_EN ? FLUSH : DRAIN) : ENCODE;
         FLUSH:        if (inject && tail_done) state_d = DRAIN;
         DRAIN:        if (pop && last_o) state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         rate_q  <= RATE_1_2;
         p_q     <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && take_in) rate_q <= rate_eff;
         if (step) begin
            p_q <= (p_q == punct_period(rate_eff) - 3'd1) ? 3'd0 : p_q + 3'd1;
         end else if (state_d == IDLE) begin
            p_q <= '0;
         end
         if (inject) tail_q <= tail_done ? '0 : tail_q + TW'(1);
      end
   end

   // Output stage: kept symbols load in C1, C2 order and shift out from entry 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sym_buf_p1 <= '0;
         sym_cnt_p1 <= '0;
         last_p1    <= 1'b0;
      end else if (step) begin
         sym_buf_p1 <= keep[1] ? {c2_sym, c1} : {1'b0, c2_sym};
         sym_cnt_p1 <= {1'b0, keep[1]} + {1'b0, keep[0]};
         last_p1    <= final_bit;
      end else if (pop) begin
         sym_buf_p1 <= {1'b0, sym_buf_p1[1]};
         sym_cnt_p1 <= sym_cnt_p1 - 2'd1;
         if (sym_cnt_p1 == 2'd1) last_p1 <= 1'b0;
      end
   end

endmodule
